// File: rtl/gcd_pkg.sv
// Shared types and parameter derivations for the GCD request sequencer.
package gcd_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_e;

  localparam int GCD_W = 16;

  // Watchdog budget is twice the worst-case subtractive GCD iteration count.
  function automatic int gcd_timeout(input int w);
    return 2 ** (w + 1);
  endfunction

  function automatic int gcd_cnt_w(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/gcd_cycle_counter.sv
// Clear/enable cycle counter with a terminal-count flag for the watchdog.
module gcd_cycle_counter #(
  parameter int CNT_W = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic [CNT_W-1:0] count_nxt;

  assign count_nxt = count + CNT_W'(1);
  // Fires in the cycle whose increment would reach the limit.
  assign expire    = en && (count_nxt == limit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count_nxt;
  end

endmodule

// File: rtl/gcd_req_sequencer.sv
// Valid/ready front-end for the GCD core: loads operands, bypasses a==0, and
// watchdogs the wait for io_valid.
module gcd_req_sequencer
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int TIMEOUT = gcd_timeout(W),
  parameter int CNT_W   = gcd_cnt_w(W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_gcd,
  output logic             out_err,
  output logic [CNT_W-1:0] out_cycles,
  output logic             gcd_load,
  output logic [W-1:0]     gcd_a,
  output logic [W-1:0]     gcd_b,
  input  logic             gcd_valid,
  input  logic [W-1:0]     gcd_out
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_nxt;
  logic             expire;

  assign cnt_nxt = count + CNT_W'(1);

  gcd_cycle_counter #(.CNT_W(CNT_W)) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .clr    (state == LOAD),
    .en     (state == WAIT),
    .limit  (LIMIT),
    .count  (count),
    .expire (expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gcd_a      <= '0;
      gcd_b      <= '0;
      out_gcd    <= '0;
      out_err    <= 1'b0;
      out_cycles <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      gcd_load   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          gcd_a    <= in_a;
          gcd_b    <= in_b;
          in_ready <= 1'b0;
          // The core never converges with a==0; answer b directly.
          if (in_a == '0) begin
            out_gcd    <= in_b;
            out_err    <= 1'b0;
            out_cycles <= '0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            gcd_load <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          gcd_load <= 1'b0;
          state    <= WAIT;
        end
        WAIT: if (gcd_valid) begin
          out_gcd    <= gcd_out;
          out_err    <= 1'b0;
          out_cycles <= cnt_nxt;
          out_valid  <= 1'b1;
          state      <= DONE;
        end else if (expire) begin
          out_gcd    <= '0;
          out_err    <= 1'b1;
          out_cycles <= cnt_nxt;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_req_sequencer.sv
// Directed scoreboard bench: sequencer paired with a behavioural subtractive GCD core.
module tb_gcd_req_sequencer;

  localparam int W     = 16;
  localparam int CNT_W = 18;

  typedef struct {
    logic [W-1:0]     g;
    logic             e;
    logic [CNT_W-1:0] c;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [W-1:0]     in_a = '0, in_b = '0;
  logic             out_valid, out_ready = 1'b1;
  logic [W-1:0]     out_gcd;
  logic             out_err;
  logic [CNT_W-1:0] out_cycles;
  logic             gcd_load;
  logic [W-1:0]     gcd_a, gcd_b;
  logic             gcd_valid;
  logic [W-1:0]     gcd_out;

  logic             stub = 1'b0;
  logic [W-1:0]     cx, cy;
  logic             core_rst;

  int   checks = 0;
  int   errors = 0;
  int   load_cnt = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  // Subtractive GCD core: valid when y reaches 0, result in x.
  assign core_rst  = ~reset;
  assign gcd_out   = cx;
  assign gcd_valid = stub ? 1'b0 : (cy == '0);

  always_ff @(posedge clock or posedge core_rst) begin
    if (core_rst) begin
      cx <= '0;
      cy <= '0;
    end else if (gcd_load) begin
      cx <= gcd_a;
      cy <= gcd_b;
    end else if (cx > cy) cx <= cx - cy;
    else                  cy <= cy - cx;
  end

  gcd_req_sequencer #(.W(W), .TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_err    (out_err),
    .out_cycles (out_cycles),
    .gcd_load   (gcd_load),
    .gcd_a      (gcd_a),
    .gcd_b      (gcd_b),
    .gcd_valid  (gcd_valid),
    .gcd_out    (gcd_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clock) if (reset && gcd_load) load_cnt++;

  // Monitor: every output handshake pops one expected result.
  always @(negedge clock) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0d expected=none", out_gcd);
      end else begin
        e = sb.pop_front();
        chk("out_gcd", 32'(out_gcd), 32'(e.g));
        chk("out_err", 32'(out_err), 32'(e.e));
        chk("out_cycles", 32'(out_cycles), 32'(e.c));
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_idle_timeout"}, 32'(ok), 32'd1);
  endtask

  // Edges from acceptance until out_valid is seen before an edge.
  task automatic measure(output int d);
    d = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (out_valid) begin
        d = i;
        break;
      end
    end
  endtask

  initial begin
    int  d;
    bit  ok;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_gcd_load", 32'(gcd_load), 32'd0);
    chk("rst_gcd_ab", {gcd_a, gcd_b}, 32'd0);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);

    // 1: normal op
    load_cnt = 0;
    sb.push_back('{16'd6, 1'b0, 18'd6});
    send(16'd48, 16'd18);
    @(negedge clock);
    chk("t1_load", 32'(gcd_load), 32'd1);
    chk("t1_gcd_a", 32'(gcd_a), 32'd48);
    chk("t1_gcd_b", 32'(gcd_b), 32'd18);
    wait_idle("t1");
    chk("t1_load_pulses", 32'(load_cnt), 32'd1);

    // 2: a==0 bypass
    load_cnt = 0;
    sb.push_back('{16'd35, 1'b0, 18'd0});
    send(16'd0, 16'd35);
    measure(d);
    chk("t2_latency", 32'(d), 32'd1);
    wait_idle("t2");
    chk("t2_load_pulses", 32'(load_cnt), 32'd0);

    // 3: b==0 minimum-latency path
    sb.push_back('{16'd7, 1'b0, 18'd1});
    send(16'd7, 16'd0);
    measure(d);
    chk("t3_latency", 32'(d), 32'd3);
    wait_idle("t3");

    // 4: output backpressure, then back-to-back op
    out_ready = 1'b0;
    sb.push_back('{16'd7, 1'b0, 18'd4});
    send(16'd21, 16'd14);
    measure(d);
    chk("t4_valid_seen", 32'(d != 0), 32'd1);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (!(out_valid && out_gcd == 16'd7 && !in_ready && out_cycles == 18'd4)) ok = 1'b0;
    end
    chk("t4_hold_stable", 32'(ok), 32'd1);
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("t4_idle_in_ready", 32'(in_ready), 32'd1);
    chk("t4_idle_out_valid", 32'(out_valid), 32'd0);
    sb.push_back('{16'd3, 1'b0, 18'd4});
    send(16'd9, 16'd6);
    wait_idle("t4b");

    // 5: watchdog with core valid stubbed low
    stub = 1'b1;
    sb.push_back('{16'd0, 1'b1, 18'd8});
    send(16'd5, 16'd3);
    measure(d);
    chk("t5_latency", 32'(d), 32'd10);
    wait_idle("t5");
    stub = 1'b0;

    // 6: async reset while in WAIT
    send(16'd12, 16'd8);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_gcd_load", 32'(gcd_load), 32'd0);
    chk("t6_gcd_a", 32'(gcd_a), 32'd0);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    sb.push_back('{16'd4, 1'b0, 18'd4});
    send(16'd12, 16'd8);
    wait_idle("t6");

    repeat (2) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
